// File: rtl/encoder0_pkg.sv
// Shared widths and FSM state encoding for the one-hot to binary encoder host.
package encoder0_pkg;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int IDX_W = 4;
    localparam int ADR_W = 13;
    localparam int SIG_W = 14;
    localparam int PAT_W = 128;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CAPTURE = 4'd1,
        S_OUTPUT  = 4'd2,
        S_WAIT    = 4'd3
    } state_t;

endpackage

// File: rtl/encoder0_prio16.sv
// Combinational lowest-set-bit priority encoder with zero and one-hot detection.
module encoder0_prio16
    import encoder0_pkg::*;
(
    input  logic [IN_W-1:0]  vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             is_zero_o,
    output logic             is_onehot_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign is_zero_o   = (vec_i == '0);
    assign is_onehot_o = !is_zero_o && ((vec_i & (vec_i - IN_W'(1))) == '0);

endmodule

// File: rtl/encoder0_host.sv
// Encoder host: enable-gated 4-state capture sequence with a one-cycle valid pulse,
// plus a free-running (enable-gated) pattern generator and program address counter.
module encoder0_host
    import encoder0_pkg::*;
#(
    parameter logic [PAT_W-1:0] ENCODE_PATTERN = 128'h0123456789ABCDEF0123456789ABCDEF,
    parameter logic [OUT_W-1:0] INVALID_CODE   = 8'hFF
) (
    input  logic             clk,
    input  logic             pon_rst_i,
    input  logic [IN_W-1:0]  decoded_input,
    input  logic             encode_enable,
    output logic [OUT_W-1:0] encoded_output,
    output logic             encode_error,
    output logic             encode_valid,
    output logic [SIG_W-1:0] signature_out,
    output logic [ADR_W-1:0] prog_adr_out
);

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               err_q, err_d;
    logic               valid_q, valid_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [ADR_W-1:0]   adr_q, adr_d;

    logic [IDX_W-1:0]   prio_idx;
    logic               prio_zero;
    logic               prio_onehot;

    encoder0_prio16 u_prio (
        .vec_i       (decoded_input),
        .idx_o       (prio_idx),
        .is_zero_o   (prio_zero),
        .is_onehot_o (prio_onehot)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        err_d   = err_q;
        valid_d = 1'b0;
        pat_d   = pat_q;
        adr_d   = adr_q;
        if (encode_enable) begin
            pat_d   = {pat_q[PAT_W-2:0], pat_q[127] ^ pat_q[95] ^ decoded_input[0]};
            adr_d   = adr_q + ADR_W'(1);
            valid_d = valid_q;
            case (state_q)
                S_IDLE: begin
                    out_d   = '0;
                    err_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    out_d   = prio_zero ? INVALID_CODE
                                        : {{(OUT_W-IDX_W){1'b0}}, prio_idx};
                    err_d   = !prio_onehot;
                    state_d = S_OUTPUT;
                end
                S_OUTPUT: begin
                    valid_d = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pon_rst_i) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            pat_q   <= ENCODE_PATTERN;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            pat_q   <= pat_d;
            adr_q   <= adr_d;
        end
    end

    assign encoded_output = out_q;
    assign encode_error   = err_q;
    assign encode_valid   = valid_q;
    assign signature_out  = pat_q[SIG_W-1:0];
    assign prog_adr_out   = adr_q;

endmodule
